// File: rtl/demultiplexer_3out_pkg.sv
// -----------------------------------------------------------------------------
// demultiplexer_3out_pkg
// Shared constants and the select decode for the 1-to-3 stream demultiplexer.
// The select encodings match the LSTM datapath's 3-input select mux, so code
// that drives either block can use the same constants.
// -----------------------------------------------------------------------------
package demultiplexer_3out_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 16;

   localparam logic [1:0] SEL_A   = 2'b00;
   localparam logic [1:0] SEL_B   = 2'b10;
   localparam logic [1:0] SEL_C   = 2'b11;
   localparam logic [1:0] SEL_ILL = 2'b01;

   typedef enum logic [1:0] {
      ROUTE_A   = 2'b00,
      ROUTE_B   = 2'b01,
      ROUTE_C   = 2'b10,
      ROUTE_ILL = 2'b11
   } route_e;

   // Map a raw 2-bit select onto a route.
   // Anything that is not a known output select is treated as illegal.
   function automatic route_e decode_sel(input logic [1:0] sel);
      case (sel)
         SEL_A:   return ROUTE_A;
         SEL_B:   return ROUTE_B;
         SEL_C:   return ROUTE_C;
         SEL_ILL: return ROUTE_ILL;
         default: return ROUTE_ILL;
      endcase
   endfunction

endpackage

// File: rtl/demultiplexer_3out_if.sv
// -----------------------------------------------------------------------------
// demultiplexer_3out_if
// Bundles the input stream, the three output slots and the error flag of
// demultiplexer_3out.
//   slave  : the demultiplexer side (takes i_*, drives o_*)
//   master : the producer/consumer side (drives i_*, observes o_*)
// Signal summary:
//   i_data/i_sel/i_valid/o_ready        input word, route select, handshake
//   o_a/o_b/o_c, o_x_valid, i_x_ready   per-output slot data and handshake
//   o_cnt_a/b/c                         delivered-word counters
//   o_err, i_err_clr                    sticky illegal-select flag and its clear
// -----------------------------------------------------------------------------
interface demultiplexer_3out_if
   import demultiplexer_3out_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);

   logic signed [WIDTH-1:0] i_data;
   logic [1:0]              i_sel;
   logic                    i_valid;
   logic                    o_ready;

   logic signed [WIDTH-1:0] o_a;
   logic signed [WIDTH-1:0] o_b;
   logic signed [WIDTH-1:0] o_c;
   logic                    o_a_valid;
   logic                    o_b_valid;
   logic                    o_c_valid;
   logic                    i_a_ready;
   logic                    i_b_ready;
   logic                    i_c_ready;

   logic [CNT_W-1:0]        o_cnt_a;
   logic [CNT_W-1:0]        o_cnt_b;
   logic [CNT_W-1:0]        o_cnt_c;

   logic                    o_err;
   logic                    i_err_clr;

   modport slave (
      input  i_data, i_sel, i_valid,
      input  i_a_ready, i_b_ready, i_c_ready,
      input  i_err_clr,
      output o_ready,
      output o_a, o_b, o_c,
      output o_a_valid, o_b_valid, o_c_valid,
      output o_cnt_a, o_cnt_b, o_cnt_c,
      output o_err
   );

   modport master (
      output i_data, i_sel, i_valid,
      output i_a_ready, i_b_ready, i_c_ready,
      output i_err_clr,
      input  o_ready,
      input  o_a, o_b, o_c,
      input  o_a_valid, o_b_valid, o_c_valid,
      input  o_cnt_a, o_cnt_b, o_cnt_c,
      input  o_err
   );

endinterface

// File: rtl/demultiplexer_3out_demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry holding register for a single demultiplexer output, with a
// wrapping counter of words handed to the consumer.
//   clk, rst   clock, asynchronous active-high reset
//   load       capture d this cycle (caller guarantees the slot is free or
//              draining in the same cycle)
//   d          word to capture
//   ready_in   consumer takes q when valid & ready_in
//   q, valid   slot contents and occupancy
//   cnt        number of words delivered, wraps silently
// -----------------------------------------------------------------------------
module demux_slot
   import demultiplexer_3out_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic signed [WIDTH-1:0] d,
   input  logic                    ready_in,
   output logic signed [WIDTH-1:0] q,
   output logic                    valid,
   output logic [CNT_W-1:0]        cnt
);

   logic signed [WIDTH-1:0] q_r;
   logic                    valid_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    drain_s;

   assign drain_s = valid_r & ready_in;

   // Slot register, occupancy and delivered counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r     <= '0;
         valid_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         // Data holds its last value after a drain; only a load replaces it.
         if (load) begin
            q_r <= d;
         end else begin
            q_r <= q_r;
         end
         // A load in the same cycle as a drain keeps the slot occupied.
         valid_r <= load | (valid_r & ~ready_in);
         if (drain_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign q     = q_r;
   assign valid = valid_r;
   assign cnt   = cnt_r;

endmodule

// File: rtl/demultiplexer_3out.sv
// -----------------------------------------------------------------------------
// demultiplexer_3out
// Registered 1-to-3 stream demultiplexer. Each accepted word is steered to
// slot A, B or C by the select captured with it; each slot has its own
// valid/ready handshake so consumers can stall independently. An illegal
// select consumes and drops the word and raises a sticky error flag.
//   clk, rst   clock, asynchronous active-high reset
//   bus        demultiplexer_3out_if.slave (stream in, three slots out,
//              delivered counters, error flag and clear)
// -----------------------------------------------------------------------------
module demultiplexer_3out
   import demultiplexer_3out_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   demultiplexer_3out_if.slave   bus
);

   route_e route_s;
   logic   ready_s;
   logic   accept_s;
   logic   ld_a_s;
   logic   ld_b_s;
   logic   ld_c_s;
   logic   ill_acc_s;
   logic   a_valid_s;
   logic   b_valid_s;
   logic   c_valid_s;
   logic   err_r;

   // Route decode, input ready and per-slot load strobes.
   always_comb begin
      route_s = decode_sel(bus.i_sel);
      ready_s = 1'b1;
      // Ready only looks at the currently selected target, so a stalled slot
      // never blocks words routed elsewhere.
      case (route_s)
         ROUTE_A:   ready_s = ~a_valid_s | bus.i_a_ready;
         ROUTE_B:   ready_s = ~b_valid_s | bus.i_b_ready;
         ROUTE_C:   ready_s = ~c_valid_s | bus.i_c_ready;
         ROUTE_ILL: ready_s = 1'b1;
         default:   ready_s = 1'b1;
      endcase
      accept_s  = bus.i_valid & ready_s;
      ld_a_s    = accept_s & (route_s == ROUTE_A);
      ld_b_s    = accept_s & (route_s == ROUTE_B);
      ld_c_s    = accept_s & (route_s == ROUTE_C);
      ill_acc_s = accept_s & (route_s == ROUTE_ILL);
   end

   assign bus.o_ready = ready_s;

   demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
      .clk      (clk),
      .rst      (rst),
      .load     (ld_a_s),
      .d        (bus.i_data),
      .ready_in (bus.i_a_ready),
      .q        (bus.o_a),
      .valid    (a_valid_s),
      .cnt      (bus.o_cnt_a)
   );

   demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
      .clk      (clk),
      .rst      (rst),
      .load     (ld_b_s),
      .d        (bus.i_data),
      .ready_in (bus.i_b_ready),
      .q        (bus.o_b),
      .valid    (b_valid_s),
      .cnt      (bus.o_cnt_b)
   );

   demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_c (
      .clk      (clk),
      .rst      (rst),
      .load     (ld_c_s),
      .d        (bus.i_data),
      .ready_in (bus.i_c_ready),
      .q        (bus.o_c),
      .valid    (c_valid_s),
      .cnt      (bus.o_cnt_c)
   );

   assign bus.o_a_valid = a_valid_s;
   assign bus.o_b_valid = b_valid_s;
   assign bus.o_c_valid = c_valid_s;

   // Sticky illegal-select flag; a new illegal accept beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (ill_acc_s) begin
         err_r <= 1'b1;
      end else if (bus.i_err_clr) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.o_err = err_r;

endmodule

// File: doc/demultiplexer_3out.md
Name: demultiplexer_3out

Overview:
- Registered 1-to-3 stream demultiplexer, the fan-out counterpart of the LSTM datapath's 3-input select mux.
- Steers each signed WIDTH-bit input word to output A, B or C, based on a 2-bit select captured with the word.
- Each output has a one-entry holding slot with valid/ready handshakes, so independent consumers (gate, cell, delta paths) can stall separately.

Parameters:
- WIDTH, 32, data word width in bits (signed two's complement)
- CNT_W, 16, width of the per-output delivered-beat counters

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- i_data  input  WIDTH  signed input word
- i_sel  input  2  route select: 00 -> A, 10 -> B, 11 -> C, 01 illegal
- i_valid  input  1  input word valid
- o_ready  output  1  input accepted this cycle when i_valid & o_ready
- o_a, o_b, o_c  output  WIDTH each  signed slot data
- o_a_valid, o_b_valid, o_c_valid  output  1 each  slot holds a word
- i_a_ready, i_b_ready, i_c_ready  input  1 each  consumer takes the word when valid & ready
- o_cnt_a, o_cnt_b, o_cnt_c  output  CNT_W each  words delivered per output
- o_err  output  1  sticky flag: illegal select accepted
- i_err_clr  input  1  synchronous clear of o_err

Behaviour:
- Reset (async, rst=1): all o_*_valid=0, o_a/o_b/o_c=0, counters=0, o_err=0. Takes effect immediately mid-transfer; in-flight slot words are discarded. Slot contents are not preserved.
- Select decode: 00=A, 10=B, 11=C, 01=illegal. Encodings match the 3-input mux.
- o_ready is combinational:
  - Legal select: 1 when the target slot is empty, or full with its consumer ready the same cycle (drain-and-refill).
  - Illegal select: always 1.
  - Valid only meaningful while i_valid=1; o_ready may depend on i_sel and i_x_ready.
- Accept (i_valid & o_ready, legal select): target slot loads i_data and sets valid on the next edge. Latency is 1 cycle from accept to o_x_valid. Non-target slots are unchanged.
- Drain (o_x_valid & i_x_ready):
  - Slot valid clears unless refilled the same cycle.
  - o_cnt_x increments by 1, wrapping from 2^CNT_W-1 to 0 with no flag.
  - Data output holds its last value after drain (not zeroed).
- Simultaneous drain and refill on the same slot: valid stays 1, data takes the new word, counter increments. Sustains one word/cycle per output.
- Several slots may drain in the same cycle; each counter updates independently.
- Illegal select (01) accepted: word consumed and dropped, no slot changes, o_err=1 next cycle.
- i_err_clr clears o_err next cycle. If an illegal accept occurs the same cycle, set wins and o_err stays 1.
- Back-pressure: while a slot is full and its consumer is not ready, words routed to it stall. Words routed to other free slots still pass, because o_ready is evaluated against the current i_sel.
- Hold rule: i_data and i_sel must stay stable while i_valid=1 and o_ready=0. Violating this is a protocol error; no check is required.
- Data passes bit-exact; no sign extension or arithmetic.

Decomposition:
- Shared package holds:
  - SEL_A=2'b00, SEL_B=2'b10, SEL_C=2'b11, SEL_ILL=2'b01 (also used by multiplexer_3in users)
  - default WIDTH and CNT_W constants
- One sub-module, demux_slot, instantiated three times:
  - one-entry holding register with load/drain/valid logic and a CNT_W wrapping delivered counter
  - ports: clk, rst, load, d, ready_in, q, valid, cnt
- Top level: select decode, o_ready mux, error flag.

Test Plan:
- Reset then single routes: send 0x0000_0005 sel=00, 0xFFFF_FFFB sel=10, 0x7FFF_FFFF sel=11, all readies=1 -> each appears on its own output one cycle after accept. Counters read 1/1/1; o_err=0.
- Back-pressure: i_a_ready=0, send two words sel=00 -> first accepted, o_ready=0 for the second. Then a sel=10 word is accepted while A stalls. Raising i_a_ready delivers the first, then the second, in order.
- Full throughput: i_b_ready=1, 8 consecutive sel=10 words 1..8 -> o_ready=1 every cycle, o_b shows 1..8 on consecutive cycles, o_cnt_b=8.
- Illegal select: send 0x1234 sel=01 -> accepted, no output valid changes, o_err=1. Then i_err_clr coincident with another sel=01 accept -> o_err stays 1; a lone clear -> 0.
- Counter wrap: CNT_W=4, deliver 17 words to C -> o_cnt_c=1.
- Mid-operation reset: assert rst asynchronously with slots A and C full -> all valids, data and counters 0 immediately. After release, normal routing resumes.
